// File: rtl/rv64_pkg.sv
// Shared RV64 fetch constants and the instruction-entry record held by the prefetch buffer.
package rv64_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Circular {pc, instr} store: up to 2 pushes and 1 pop per cycle, synchronous clear.
// The head presents registered storage; an empty queue keeps showing the last head seen.
module instr_fifo import rv64_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic [1:0]             i_push_n,
  input  logic [XLEN-1:0]        i_push0_pc,
  input  logic [ILEN-1:0]        i_push0_instr,
  input  logic [XLEN-1:0]        i_push1_pc,
  input  logic [ILEN-1:0]        i_push1_instr,
  input  logic                   i_pop,
  output logic [XLEN-1:0]        o_head_pc,
  output logic [ILEN-1:0]        o_head_instr,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  fetch_entry_t   r_last;
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [CW-1:0]  r_count;
  logic [PW-1:0]  w_wr_next;
  logic           w_pop;
  logic           w_nonempty;
  fetch_entry_t   w_head;

  assign w_nonempty = (r_count != '0);
  assign w_pop      = i_pop && w_nonempty;
  assign w_wr_next  = r_wr + PW'(1);
  assign w_head     = w_nonempty ? r_mem[r_rd] : r_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push_n != 2'd0) r_mem[r_wr]      <= '{pc: i_push0_pc, instr: i_push0_instr};
      if (i_push_n == 2'd2) r_mem[w_wr_next] <= '{pc: i_push1_pc, instr: i_push1_instr};
      r_wr    <= r_wr + PW'(i_push_n);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + CW'(i_push_n) - CW'(w_pop);
    end
  end

  // Shadow of the visible head so the outputs hold across empty periods and flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= '0;
    end else if (w_nonempty) begin
      r_last <= r_mem[r_rd];
    end
  end

  assign o_head_pc    = w_head.pc;
  assign o_head_instr = w_head.instr;
  assign o_count      = r_count;

endmodule

// File: rtl/prefetch_buffer.sv
// Instruction prefetcher: one 64-bit word read in flight, 2-cycle issue-to-out_valid latency.
// Reads only start with room for two entries, so a full buffer stalls fetch and never overwrites.
module prefetch_buffer import rv64_pkg::*; #(
  parameter int              ADDR_WIDTH = 10,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_re,
  input  logic [63:0]            mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:2] r_fetch_pc;
  logic [XLEN-1:2] r_req_pc;
  logic            r_outstanding;
  logic            r_drop;

  logic            w_space;
  logic            w_ret;
  logic [1:0]      w_push_n;
  logic [XLEN-1:0] w_push0_pc;
  logic [ILEN-1:0] w_push0_instr;
  logic [XLEN-1:0] w_push1_pc;
  logic [ILEN-1:0] w_push1_instr;
  logic            w_pop;
  logic            w_unused;

  assign w_unused = ^redirect_pc[1:0];

  assign mem_addr = r_fetch_pc[ADDR_WIDTH+2:3];
  assign w_space  = (count <= CW'(DEPTH - 2));
  assign mem_re   = !r_outstanding && !rst && !redirect_valid && w_space;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC[XLEN-1:2];
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_outstanding <= mem_re;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc[XLEN-1:2];
        r_drop     <= r_outstanding;
      end else if (mem_re) begin
        r_fetch_pc <= {r_fetch_pc[XLEN-1:3] + 61'd1, 1'b0};
        r_req_pc   <= r_fetch_pc;
        r_drop     <= 1'b0;
      end
    end
  end

  // A return landing in a redirect cycle belongs to the old stream and is discarded.
  assign w_ret         = r_outstanding && !r_drop && !redirect_valid;
  assign w_push_n      = !w_ret ? 2'd0 : (r_req_pc[2] ? 2'd1 : 2'd2);
  assign w_push0_pc    = {r_req_pc[XLEN-1:3], r_req_pc[2], 2'b00};
  assign w_push0_instr = r_req_pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];
  assign w_push1_pc    = {r_req_pc[XLEN-1:3], 3'b100};
  assign w_push1_instr = mem_rdata[63:32];

  assign out_valid = (count != '0);
  assign w_pop     = out_valid && out_ready;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .i_clr         (redirect_valid),
    .i_push_n      (w_push_n),
    .i_push0_pc    (w_push0_pc),
    .i_push0_instr (w_push0_instr),
    .i_push1_pc    (w_push1_pc),
    .i_push1_instr (w_push1_instr),
    .i_pop         (w_pop),
    .o_head_pc     (out_pc),
    .o_head_instr  (out_instr),
    .o_count       (count)
  );

endmodule
